// File: rtl/clock_monitor.sv
// clock_monitor: measures period/high time of a slow clock in clk cycles, reports lock and loss.
// Define CLOCK_MONITOR_IRQ_EN to build the sticky status-change interrupt.
module clock_monitor #(
  parameter int COUNT_W         = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EXPECTED_PERIOD = 16,
  parameter int TOLERANCE       = 1,
  parameter int LOCK_COUNT      = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_in,
  input  logic               enable,
  output logic [COUNT_W-1:0] period,
  output logic [COUNT_W-1:0] high_time,
  output logic               valid,
  output logic               locked,
  output logic               lost,
  output logic               irq,
  input  logic               irq_clr
);
  localparam logic [1:0] IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2, LOST = 2'd3;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  logic [1:0] state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic s_d, rise, fall, in_spec, timeout, tracking_rise;
  logic [COUNT_W-1:0] cnt, meas;
  logic [LW-1:0] lock_cnt;
  assign rise = sync[SYNC_STAGES-1] & ~s_d;
  assign fall = ~sync[SYNC_STAGES-1] & s_d;
  assign meas = &cnt ? cnt : cnt + 1'b1;
  assign in_spec = int'(meas) >= EXPECTED_PERIOD - TOLERANCE && int'(meas) <= EXPECTED_PERIOD + TOLERANCE;
  assign timeout = int'(meas) >= TIMEOUT;
  assign tracking_rise = enable && state == TRACK && rise;
  assign lost = state == LOST;
  // rise beats a coincident timeout, so a late edge keeps tracking
  always_comb
    state_n = !enable ? IDLE :
              state == IDLE ? ACQUIRE :
              (state == ACQUIRE || state == LOST) && rise ? TRACK :
              state == TRACK && !rise && timeout ? LOST : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync      <= '0;
      s_d       <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], clk_in};
      s_d   <= sync[SYNC_STAGES-1];
      state <= state_n;
      cnt   <= state == IDLE || rise ? '0 : meas;
      valid <= tracking_rise;
      if (!enable || state_n == LOST) begin
        locked   <= 1'b0;
        lock_cnt <= '0;
      end else if (tracking_rise) begin
        period   <= meas;
        lock_cnt <= !in_spec ? '0 : lock_cnt == LW'(LOCK_COUNT) ? lock_cnt : lock_cnt + 1'b1;
        locked   <= in_spec && lock_cnt >= LW'(LOCK_COUNT - 1);
      end
      if (enable && state == TRACK && fall) high_time <= meas;
    end
`ifdef CLOCK_MONITOR_IRQ_EN
  logic locked_d, lost_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      locked_d <= 1'b0;
      lost_d   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      locked_d <= locked;
      lost_d   <= lost;
      irq      <= (locked ^ locked_d) | (lost ^ lost_d) | (irq & ~irq_clr);
    end
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: timestamp-based reference model with per-cycle compare, directed plus random clk_in.
module tb_clock_monitor;
  localparam int S = 2, EXP = 16, TOL = 1, LC = 4, TO = 64;
  logic clk = 0, rst = 1, clk_in = 0, enable = 0, irq_clr = 0;
  logic [7:0] period, high_time;
  logic valid, locked, lost, irq;
  int tests = 0, fails = 0;

  clock_monitor dut (
    .clk(clk), .rst(rst), .clk_in(clk_in), .enable(enable),
    .period(period), .high_time(high_time), .valid(valid),
    .locked(locked), .lost(lost), .irq(irq), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  function automatic void check(string n, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endfunction

  // model: clk_in samples delayed through the synchronizer, periods from edge timestamps
  logic xs [0:S+1];
  logic r, f, m_valid, m_locked, m_lost, m_irq, p_locked, p_lost;
  int phase, cyc, last, run, d, m_period, m_high;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (xs[i]) xs[i] = 1'b0;
      phase = 0; cyc = 0; last = 0; run = 0; m_period = 0; m_high = 0;
      m_valid = 0; m_locked = 0; m_lost = 0; m_irq = 0; p_locked = 0; p_lost = 0;
    end else begin
      for (int i = S + 1; i > 0; i--) xs[i] = xs[i-1];
      xs[0] = clk_in;
      r = xs[S] && !xs[S+1];
      f = !xs[S] && xs[S+1];
      cyc++;
      d = cyc - last > 255 ? 255 : cyc - last;
`ifdef CLOCK_MONITOR_IRQ_EN
      m_irq = (m_locked != p_locked || m_lost != p_lost) ? 1'b1 : irq_clr ? 1'b0 : m_irq;
      p_locked = m_locked;
      p_lost = m_lost;
`endif
      m_valid = 0;
      if (!enable) begin
        phase = 0; m_locked = 0; run = 0;
      end else case (phase)
        0: phase = 1;
        1: if (r) begin phase = 2; last = cyc; end
        2: if (r) begin
             m_period = d; m_valid = 1;
             run = (d >= EXP - TOL && d <= EXP + TOL) ? run + 1 : 0;
             m_locked = run >= LC;
             last = cyc;
           end else begin
             if (f) m_high = d;
             if (d >= TO) begin phase = 3; m_locked = 0; run = 0; end
           end
        default: if (r) begin phase = 2; last = cyc; end
      endcase
      m_lost = phase == 3;
    end
  end

  always @(negedge clk) if (!rst) begin
    check("cmp_period", period, m_period);
    check("cmp_high_time", high_time, m_high);
    check("cmp_valid", valid, m_valid);
    check("cmp_locked", locked, m_locked);
    check("cmp_lost", lost, m_lost);
    check("cmp_irq", irq, m_irq);
  end

  task automatic cyc_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(int hi, int lo, int n);
    repeat (n) begin
      clk_in = 1; cyc_n(hi);
      clk_in = 0; cyc_n(lo);
    end
  endtask

  initial begin
    cyc_n(2);
    check("reset_period", period, 0);
    check("reset_locked", locked, 0);
    check("reset_lost", lost, 0);
    check("reset_irq", irq, 0);
    rst = 0; enable = 1;
    wave(8, 8, 10);
    check("ideal_period", period, 16);
    check("ideal_high", high_time, 8);
    check("ideal_locked", locked, 1);
    check("ideal_lost", lost, 0);
    wave(5, 11, 6);
    check("duty_high", high_time, 5);
    check("duty_locked", locked, 1);
    wave(8, 11, 1);
    clk_in = 1; cyc_n(5);
    check("p19_period", period, 19);
    check("p19_locked", locked, 0);
    cyc_n(3); clk_in = 0; cyc_n(8);
    wave(8, 8, 6);
    check("relock", locked, 1);
    wave(8, 9, 2);
    clk_in = 1; cyc_n(5);
    check("p17_period", period, 17);
    check("p17_locked", locked, 1);
    cyc_n(3); clk_in = 0; cyc_n(78);
    check("timeout_lost", lost, 1);
    check("timeout_locked", locked, 0);
    wave(8, 8, 6);
    check("restart_lost", lost, 0);
    check("restart_locked", locked, 1);
`ifdef CLOCK_MONITOR_IRQ_EN
    check("irq_set", irq, 1);
    irq_clr = 1; cyc_n(1); irq_clr = 0; cyc_n(1);
    check("irq_cleared", irq, 0);
`else
    check("irq_off", irq, 0);
`endif
    enable = 0; cyc_n(1);
    check("dis_locked", locked, 0);
    check("dis_period_hold", period, 16);
    enable = 1;
    wave(8, 8, 3);
    clk_in = 1; cyc_n(3);
    #3 rst = 1;
    #1;
    check("arst_period", period, 0);
    check("arst_high", high_time, 0);
    check("arst_locked", locked, 0);
    cyc_n(2); rst = 0;
    repeat (160) begin
      irq_clr = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 9) == 0) begin
        enable = 0; cyc_n($urandom_range(1, 5)); enable = 1;
      end
      if ($urandom_range(0, 11) == 0) wave($urandom_range(3, 12), $urandom_range(55, 90), 1);
      else wave($urandom_range(4, 12), $urandom_range(4, 12), 1);
    end
    irq_clr = 0;
    cyc_n(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clock_monitor.md
Name: clock_monitor

Overview:
Receive-side companion to the system clock divider. Samples a slow derived clock (nominally the 1 MHz divider output) in the 16 MHz `clk` domain and measures its period and high time in `clk` cycles. Reports lock when the measured period stays within tolerance of the expected value, and flags loss of clock. Used for bring-up checks and for run-time health monitoring of derived clocks.

Parameters:
- COUNT_W, 8: width of the period/high-time counters and outputs.
- SYNC_STAGES, 2: number of synchronizer flops on clk_in; minimum 2.
- EXPECTED_PERIOD, 16: nominal clk_in period in clk cycles.
- TOLERANCE, 1: allowed |period - EXPECTED_PERIOD| for an in-spec period.
- LOCK_COUNT, 4: consecutive in-spec periods required to assert locked.
- TIMEOUT, 64: clk cycles without a synced rising edge before lost asserts; must be below 2^COUNT_W.

Ports:
- clk  in  1  system clock (16 MHz).
- rst  in  1  reset; asynchronous, active-high.
- clk_in  in  1  monitored slow clock; asynchronous to clk.
- enable  in  1  monitor enable.
- period  out  COUNT_W  last measured period in clk cycles.
- high_time  out  COUNT_W  last measured high phase in clk cycles.
- valid  out  1  one-cycle pulse when period/high_time update.
- locked  out  1  clk_in period stable and in tolerance.
- lost  out  1  no clk_in rising edge for TIMEOUT cycles.
- irq  out  1  sticky status-change interrupt (optional feature).
- irq_clr  in  1  clears irq (optional feature).

Behaviour:
- Reset: all state, counters, period, high_time, valid, locked, lost and irq are 0; FSM is IDLE.
- Synchronizer: clk_in passes through SYNC_STAGES flops to give s. One more flop gives s_d. rise = s & ~s_d; fall = ~s & s_d. A clk_in edge shows up as rise/fall SYNC_STAGES+1 clk cycles after the first sampling clk edge.
- Counter cnt: cleared to 0 in the cycle rise is seen. Otherwise increments each cycle, saturating at 2^COUNT_W-1. Measured values are cnt+1, saturating.
- FSM states: IDLE, ACQUIRE, TRACK, LOST.
  - IDLE: counters held at 0. Goes to ACQUIRE when enable=1.
  - ACQUIRE: waits for the first rise. On rise, clears cnt and goes to TRACK. No valid is produced.
  - TRACK:
    - On fall, latch high_time <= cnt+1.
    - On rise: period <= cnt+1, valid=1 on the next cycle (registered), cnt cleared.
    - In-spec period: lock counter increments, saturating at LOCK_COUNT; locked=1 once it reaches LOCK_COUNT.
    - Out-of-spec period: lock counter reset to 0, locked=0 immediately.
    - If cnt+1 reaches TIMEOUT with no rise: go to LOST.
  - LOST: lost=1, locked=0, lock counter 0, period/high_time held. The next rise clears lost and cnt and returns to TRACK. The period measured at that rise is not reported.
- Simultaneous rise and timeout in the same cycle: rise wins; no LOST.
- enable=0 in any state: next cycle goes to IDLE; locked, lost, valid and the lock counter clear; period/high_time hold.
- Reset mid-operation: immediate return to reset values regardless of state.
- A fall seen in ACQUIRE or LOST is ignored.

Optional Feature:
- Macro: CLOCK_MONITOR_IRQ_EN.
- Defined: irq is set on any rising or falling transition of locked or lost, and stays set until irq_clr=1. If a set event and irq_clr occur in the same cycle, set wins. The irq register resets to 0.
- Not defined: irq is tied to 0, irq_clr is ignored, and no irq logic is synthesized. Ports are present in both builds.

Test Plan:
- Ideal divider stimulus (clk_in toggles every 8 clk cycles, enable=1 from reset) -> first valid at the second synced rise with period=16 and high_time=8; locked=1 after the 4th in-spec valid; lost=0 throughout.
- Duty change (5 cycles high, 11 cycles low) -> period=16, high_time=5, locked stays 1.
- Period 19 (TOLERANCE=1) after lock -> locked drops on that valid; periods of 16 then re-lock after 4 valids. Period 17 keeps lock.
- clk_in held low after lock -> lost=1 when 64 cycles have passed since the last rise, locked=0; clk_in restarted -> lost=0 one cycle after the first synced rise, no valid for that edge.
- enable deasserted mid-TRACK, then rst pulsed asynchronously mid-period -> locked/lost/valid=0 on the next cycle after enable=0; all outputs 0 immediately on rst.
- With CLOCK_MONITOR_IRQ_EN defined: irq sets on the lock assertion and stays set until irq_clr; irq_clr in the same cycle as the lost assertion leaves irq=1. Without the macro: irq=0 in every scenario.
